// File: rtl/rst_seq_if.sv
// Purpose: control/status bundle between a reset sequencer and its clock domain.
// Latency: wiring only; the sequencer registers everything it drives.
// Backpressure: none; ch_ready is a per-channel level acknowledge.
interface rst_seq_if #(
  parameter int unsigned NUM_CH = 4
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Domain -> sequencer
  logic              rst_req;
  logic              locked;
  logic [NUM_CH-1:0] ch_ready;

  // Sequencer -> domain
  logic [NUM_CH-1:0] rst_out;
  logic              seq_done;
  logic              err;
  logic [CH_W-1:0]   err_ch;

  // Environment side: drives requests/acks, observes resets and status
  modport master (
    output rst_req,
    output locked,
    output ch_ready,
    input  rst_out,
    input  seq_done,
    input  err,
    input  err_ch
  );

  // Sequencer side
  modport slave (
    input  rst_req,
    input  locked,
    input  ch_ready,
    output rst_out,
    output seq_done,
    output err,
    output err_ch
  );
endinterface

// File: rtl/rst_seq.sv
// Purpose: multi-channel reset sequencer; holds resets through a lock-qualified pulse, then releases channels in index order.
// Latency: all outputs registered; channel 0 releases PULSE_LEN cycles after continuous lock begins.
// Backpressure: each release waits on ch_ready[k] (unless masked), with timeout, error flag and full retry.
module rst_seq #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       PULSE_LEN  = 16,
  parameter int unsigned       STAGGER    = 8,
  parameter int unsigned       TIMEOUT    = 1024,
  parameter logic [NUM_CH-1:0] READY_MASK = {NUM_CH{1'b1}}
) (
  input  logic     clk,
  input  logic     rst,
  rst_seq_if.slave bus
);

  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MAX_A   = (PULSE_LEN > STAGGER) ? PULSE_LEN : STAGGER;
  localparam int unsigned MAX_CNT = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  // Terminal counts. The timeout compares against TIMEOUT-2 because the
  // release cycle itself counts as the first cycle of waiting, so the
  // retry fires TIMEOUT cycles after rst_out[k] falls.
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 2);
  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_ASSERT   = 3'd0,
    S_RELEASE  = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_GAP      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [CH_W-1:0]   k_q,        k_d;
  logic [NUM_CH-1:0] rst_out_q,  rst_out_d;
  logic              seq_done_q, seq_done_d;
  logic              err_q,      err_d;
  logic [CH_W-1:0]   err_ch_q,   err_ch_d;

  logic              abort;
  logic              need_rdy;
  logic              ready_k;
  logic [CH_W-1:0]   k_inc;
  logic [NUM_CH-1:0] next_bit;

  // Soft request or lock loss restarts the whole sequence.
  assign abort    = bus.rst_req | ~bus.locked;
  // Only the channel currently being released is looked at; masked
  // channels count as ready immediately.
  assign need_rdy = READY_MASK[k_q];
  assign ready_k  = ~need_rdy | bus.ch_ready[k_q];
  assign k_inc    = k_q + CH_W'(1);
  assign next_bit = NUM_CH'(1) << k_inc;

  // Next-state and next-output computation for the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    rst_out_d  = rst_out_q;
    seq_done_d = seq_done_q;
    err_d      = err_q;
    err_ch_d   = err_ch_q;

    if (state_q != S_ASSERT && abort) begin
      // Abort outranks timeout and ready; err/err_ch are left alone.
      state_d    = S_ASSERT;
      cnt_d      = '0;
      k_d        = '0;
      rst_out_d  = '1;
      seq_done_d = 1'b0;
    end else begin
      case (state_q)
        S_ASSERT: begin
          rst_out_d  = '1;
          seq_done_d = 1'b0;
          if (abort) begin
            // Lock must be continuous and no request pending.
            cnt_d = '0;
          end else if (cnt_q == PULSE_LAST) begin
            // Clear bit 0 together with the state change so rst_out[0]
            // is already low in the RELEASE cycle.
            state_d   = S_RELEASE;
            cnt_d     = '0;
            k_d       = '0;
            rst_out_d = ~NUM_CH'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_RELEASE: begin
          state_d = S_WAIT_RDY;
          cnt_d   = '0;
        end

        S_WAIT_RDY: begin
          if (need_rdy && cnt_q == TIMEOUT_LAST) begin
            // Timeout wins over a ready arriving on the same cycle.
            state_d   = S_ASSERT;
            cnt_d     = '0;
            k_d       = '0;
            rst_out_d = '1;
            err_d     = 1'b1;
            err_ch_d  = k_q;
          end else if (ready_k) begin
            cnt_d = '0;
            if (k_q == LAST_CH) begin
              state_d    = S_DONE;
              seq_done_d = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_GAP: begin
          // ch_ready is deliberately not looked at here.
          if (cnt_q == GAP_LAST) begin
            state_d   = S_RELEASE;
            cnt_d     = '0;
            k_d       = k_inc;
            rst_out_d = rst_out_q & ~next_bit;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_DONE: begin
          rst_out_d  = '0;
          seq_done_d = 1'b1;
        end

        default: begin
          state_d    = S_ASSERT;
          cnt_d      = '0;
          k_d        = '0;
          rst_out_d  = '1;
          seq_done_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; rst returns everything to power-on values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ASSERT;
      cnt_q      <= '0;
      k_q        <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
    end
  end

  assign bus.rst_out  = rst_out_q;
  assign bus.seq_done = seq_done_q;
  assign bus.err      = err_q;
  assign bus.err_ch   = err_ch_q;

endmodule

// File: tb/tb_rst_seq.sv
// Purpose: directed bench for rst_seq; expected outputs queued per cycle and checked as the DUT advances.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: ch_ready driven directly by the bench.
module tb_rst_seq;

  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rst_seq_if #(.NUM_CH(NCH)) bus ();

  rst_seq #(
    .NUM_CH    (NCH),
    .PULSE_LEN (4),
    .STAGGER   (2),
    .TIMEOUT   (8),
    .READY_MASK(3'b011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [2:0] ro;
    logic       done;
    logic       er;
    logic [1:0] ech;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push_range(input int c0, input int c1, input logic [2:0] ro,
                            input logic done, input logic er, input logic [1:0] ech);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc = c; e.ro = ro; e.done = done; e.er = er; e.ech = ech;
      sb.push_back(e);
    end
  endtask

  // Pop and compare every expectation due at or before the current cycle.
  task automatic check_head();
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_assert++;
      assert (e.cyc == cyc) else begin
        n_fail++; $error("FAIL sched: checked at cycle %0d, expected cycle %0d", cyc, e.cyc);
      end
      n_assert++;
      assert (bus.rst_out === e.ro) else begin
        n_fail++; $error("FAIL rst_out cyc=%0d got %b exp %b", cyc, bus.rst_out, e.ro);
      end
      n_assert++;
      assert (bus.seq_done === e.done) else begin
        n_fail++; $error("FAIL seq_done cyc=%0d got %b exp %b", cyc, bus.seq_done, e.done);
      end
      n_assert++;
      assert (bus.err === e.er) else begin
        n_fail++; $error("FAIL err cyc=%0d got %b exp %b", cyc, bus.err, e.er);
      end
      n_assert++;
      assert (bus.err_ch === e.ech) else begin
        n_fail++; $error("FAIL err_ch cyc=%0d got %0d exp %0d", cyc, bus.err_ch, e.ech);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_head();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Cycle 0 is the first cycle with rst low; reset values are visible then.
  task automatic do_reset(input logic lk);
    rst          = 1'b1;
    bus.locked   = lk;
    bus.rst_req  = 1'b0;
    bus.ch_ready = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check_drained(input string tag);
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++; $error("FAIL drained_%s: %0d expectations left, 0 required", tag, sb.size());
    end
  endtask

  // Nominal release sequence starting with ASSERT at cycle base.
  task automatic run_nominal(input int base);
    push_range(base,      base + 3,  3'b111, 1'b0, 1'b0, 2'd0);
    push_range(base + 4,  base + 8,  3'b110, 1'b0, 1'b0, 2'd0);
    push_range(base + 9,  base + 12, 3'b100, 1'b0, 1'b0, 2'd0);
    push_range(base + 13, base + 14, 3'b000, 1'b0, 1'b0, 2'd0);
    push_range(base + 15, base + 16, 3'b000, 1'b1, 1'b0, 2'd0);
    check_head();
    run_to(base);
    bus.rst_req  = 1'b0;
    bus.ch_ready = '0;
    run_to(base + 6);
    bus.ch_ready[0] = 1'b1;
    run_to(base + 10);
    bus.ch_ready[1] = 1'b1;
    run_to(base + 16);
  endtask

  initial begin
    // Nominal sequence, then soft reset while DONE and an identical replay.
    do_reset(1'b1);
    run_nominal(0);
    push_range(17, 20, 3'b000, 1'b1, 1'b0, 2'd0);
    run_to(20);
    bus.rst_req = 1'b1;
    run_nominal(21);
    check_drained("nominal");

    // Lock lost while in GAP after channel 0.
    do_reset(1'b1);
    push_range(0,  3,  3'b111, 1'b0, 1'b0, 2'd0);
    push_range(4,  7,  3'b110, 1'b0, 1'b0, 2'd0);
    push_range(8,  13, 3'b111, 1'b0, 1'b0, 2'd0);
    push_range(14, 17, 3'b110, 1'b0, 1'b0, 2'd0);
    push_range(18, 18, 3'b100, 1'b0, 1'b0, 2'd0);
    check_head();
    run_to(6);
    bus.ch_ready[0] = 1'b1;
    run_to(7);
    bus.locked = 1'b0;
    run_to(10);
    bus.locked = 1'b1;
    run_to(18);
    check_drained("lockloss");

    // Lock gating with a 2-cycle glitch before stable lock at cycle 15.
    do_reset(1'b0);
    push_range(0,  18, 3'b111, 1'b0, 1'b0, 2'd0);
    push_range(19, 19, 3'b110, 1'b0, 1'b0, 2'd0);
    check_head();
    run_to(10);
    bus.locked = 1'b1;
    run_to(12);
    bus.locked = 1'b0;
    run_to(15);
    bus.locked = 1'b1;
    run_to(19);
    check_drained("lockgate");

    // Channel 1 never ready: repeated timeouts, then rst on a timeout cycle.
    do_reset(1'b1);
    push_range(0,  3,  3'b111, 1'b0, 1'b0, 2'd0);
    push_range(4,  8,  3'b110, 1'b0, 1'b0, 2'd0);
    push_range(9,  16, 3'b100, 1'b0, 1'b0, 2'd0);
    push_range(17, 20, 3'b111, 1'b0, 1'b1, 2'd1);
    push_range(21, 24, 3'b110, 1'b0, 1'b1, 2'd1);
    push_range(25, 32, 3'b100, 1'b0, 1'b1, 2'd1);
    push_range(33, 36, 3'b111, 1'b0, 1'b1, 2'd1);
    push_range(37, 40, 3'b110, 1'b0, 1'b1, 2'd1);
    push_range(41, 48, 3'b100, 1'b0, 1'b1, 2'd1);
    push_range(49, 49, 3'b111, 1'b0, 1'b0, 2'd0);
    check_head();
    run_to(6);
    bus.ch_ready[0] = 1'b1;
    run_to(48);
    rst             = 1'b1;
    bus.ch_ready[1] = 1'b1;
    run_to(49);
    rst = 1'b0;
    check_drained("timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
